// File: rtl/board_mem_arbiter_pkg.sv
// Shared constants for the Tetrix board RAM arbiter: board geometry, FSM encodings, owner codes.
// Optional build macro BOARD_ARB_RR_EN selects round-robin arbitration in board_arb_prio.
package board_mem_arbiter_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_DISP = 1'b0;
    localparam logic OWN_GAME = 1'b1;

    function automatic logic [3:0] sat_inc4(input logic [3:0] value, input logic [3:0] limit);
        if (value >= limit) begin
            return limit;
        end else begin
            return value + 4'd1;
        end
    endfunction

endpackage

// File: rtl/board_arb_prio.sv
// Winner pick for the board RAM arbiter: display priority with a starvation guard by default,
// or round-robin when BOARD_ARB_RR_EN is defined. pick = 1 means the game engine wins.
module board_arb_prio
    import board_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_in,
    input  logic rst,
    input  logic disp_req,
    input  logic game_req,
    input  logic sample,
    output logic pick
);

`ifdef BOARD_ARB_RR_EN
    logic last_r;

    // Round-robin winner: the client not granted last wins a tie
    always_comb begin
        if (disp_req && game_req) begin
            pick = ~last_r;
        end else if (game_req) begin
            pick = OWN_GAME;
        end else begin
            pick = OWN_DISP;
        end
    end

    // Last-owner register; reset favours display on the first tie
    always_ff @(posedge clk_in) begin
        if (rst) begin
            last_r <= OWN_GAME;
        end else if (sample) begin
            last_r <= pick;
        end else begin
            last_r <= last_r;
        end
    end
`else
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    logic [3:0] wait_cnt_r;

    // Display wins ties unless the game has already lost MAX_WAIT times in a row
    always_comb begin
        if (game_req && (!disp_req || (wait_cnt_r == MAX_WAIT_C))) begin
            pick = OWN_GAME;
        end else begin
            pick = OWN_DISP;
        end
    end

    // Starvation counter: counts display wins over a pending game request
    always_ff @(posedge clk_in) begin
        if (rst) begin
            wait_cnt_r <= 4'd0;
        end else if (!game_req) begin
            wait_cnt_r <= 4'd0;
        end else if (sample && (pick == OWN_GAME)) begin
            wait_cnt_r <= 4'd0;
        end else if (sample) begin
            wait_cnt_r <= sat_inc4(wait_cnt_r, MAX_WAIT_C);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end
`endif

endmodule

// File: rtl/board_mem_arbiter.sv
// Two-client arbiter/sequencer for the Tetrix board RAM (display reads, game reads/writes).
// Build macro BOARD_ARB_RR_EN switches arbitration to round-robin (see board_arb_prio).
module board_mem_arbiter
    import board_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = $clog2(BOARD_ROWS),
    parameter int DATA_W   = BOARD_COLS,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic              game_rvalid,
    output logic [DATA_W-1:0] game_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        state_r;
    logic              owner_r;
    logic              sample_s;
    logic              pick_s;
    logic [DATA_W-1:0] disp_hold_r;
    logic [DATA_W-1:0] game_hold_r;

    assign sample_s = (state_r != ST_ACC) && (disp_req || game_req);

    board_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk_in   (clk_in),
        .rst      (rst),
        .disp_req (disp_req),
        .game_req (game_req),
        .sample   (sample_s),
        .pick     (pick_s)
    );

    // Sequencer FSM plus registered grant, RAM command and read-valid outputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWN_DISP;
            disp_gnt    <= 1'b0;
            game_gnt    <= 1'b0;
            disp_rvalid <= 1'b0;
            game_rvalid <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            disp_gnt    <= 1'b0;
            game_gnt    <= 1'b0;
            disp_rvalid <= 1'b0;
            game_rvalid <= 1'b0;
            mem_en      <= 1'b0;
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if (sample_s) begin
                        state_r <= ST_ACC;
                        owner_r <= pick_s;
                        mem_en  <= 1'b1;
                        if (pick_s == OWN_GAME) begin
                            game_gnt  <= 1'b1;
                            mem_we    <= game_we;
                            mem_addr  <= game_addr;
                            mem_wdata <= game_wdata;
                        end else begin
                            disp_gnt  <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= disp_addr;
                            mem_wdata <= mem_wdata;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        mem_we  <= 1'b0;
                    end
                end
                ST_ACC: begin
                    // mem_we still carries the access type issued this cycle
                    state_r     <= ST_RESP;
                    mem_we      <= 1'b0;
                    disp_rvalid <= !mem_we && (owner_r == OWN_DISP);
                    game_rvalid <= !mem_we && (owner_r == OWN_GAME);
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    // Per-client copy of the last delivered row so the non-owner's rdata stays stable
    always_ff @(posedge clk_in) begin
        if (rst) begin
            disp_hold_r <= '0;
            game_hold_r <= '0;
        end else begin
            if (disp_rvalid) begin
                disp_hold_r <= mem_rdata;
            end else begin
                disp_hold_r <= disp_hold_r;
            end
            if (game_rvalid) begin
                game_hold_r <= mem_rdata;
            end else begin
                game_hold_r <= game_hold_r;
            end
        end
    end

    // RAM data passes straight through in the response cycle, otherwise the held row
    always_comb begin
        disp_rdata = disp_hold_r;
        game_rdata = game_hold_r;
        if (disp_rvalid) begin
            disp_rdata = mem_rdata;
        end else begin
            disp_rdata = disp_hold_r;
        end
        if (game_rvalid) begin
            game_rdata = mem_rdata;
        end else begin
            game_rdata = game_hold_r;
        end
    end

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Scoreboard bench for board_mem_arbiter: directed stimulus pushes expected grants and reads,
// a negedge monitor pops and compares them against the DUT and a 1-cycle RAM model.
module tb_board_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 10;

    logic          clk_in = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          game_req;
    logic          game_we;
    logic [AW-1:0] game_addr;
    logic [DW-1:0] game_wdata;
    logic          game_gnt;
    logic          game_rvalid;
    logic [DW-1:0] game_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk_in = ~clk_in;

    board_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .game_req    (game_req),
        .game_we     (game_we),
        .game_addr   (game_addr),
        .game_wdata  (game_wdata),
        .game_gnt    (game_gnt),
        .game_rvalid (game_rvalid),
        .game_rdata  (game_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Behavioural 1-cycle RAM; fixed rows are preloaded while reset is high
    logic [DW-1:0] ram [0:31];
    always @(posedge clk_in) begin
        if (rst) begin
            ram[3] <= 10'h0A5;
            ram[5] <= 10'h3FF;
            ram[7] <= 10'h12C;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        logic          own;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            gap;
    } gnt_t;
    typedef struct {
        logic          own;
        logic [DW-1:0] data;
    } rv_t;

    gnt_t gnt_q[$];
    rv_t  rv_q[$];
    gnt_t ge;
    rv_t  re;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_gnt_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_gnt(input logic own, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int gap);
        gnt_q.push_back('{own, we, a, wd, gap});
    endtask

    task automatic exp_rv(input logic own, input logic [DW-1:0] d);
        rv_q.push_back('{own, d});
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant or read data
    always @(negedge clk_in) begin
        cyc++;
        if (disp_rvalid || game_rvalid) begin
            check("rvalid_exclusive", 32'(disp_rvalid & game_rvalid), 32'd0);
            check("rvalid_latency", 32'(cyc - last_gnt_cyc), 32'd1);
            if (rv_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rvalid: got disp=%0b game=%0b, expected none", disp_rvalid, game_rvalid);
            end else begin
                re = rv_q.pop_front();
                check("rvalid_owner", 32'(game_rvalid), 32'(re.own));
                check("rdata", 32'(re.own ? game_rdata : disp_rdata), 32'(re.data));
            end
        end
        if (disp_gnt || game_gnt) begin
            check("gnt_exclusive", 32'(disp_gnt & game_gnt), 32'd0);
            check("gnt_mem_en", 32'(mem_en), 32'd1);
            if (gnt_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_gnt: got disp=%0b game=%0b, expected none", disp_gnt, game_gnt);
            end else begin
                ge = gnt_q.pop_front();
                check("gnt_owner", 32'(game_gnt), 32'(ge.own));
                check("gnt_mem_we", 32'(mem_we), 32'(ge.we));
                check("gnt_mem_addr", 32'(mem_addr), 32'(ge.addr));
                if (ge.we) check("gnt_mem_wdata", 32'(mem_wdata), 32'(ge.wdata));
                if (ge.gap != 0) check("gnt_spacing", 32'(cyc - last_gnt_cyc), 32'(ge.gap));
            end
            last_gnt_cyc = cyc;
        end else if (mem_en) begin
            check("mem_en_without_gnt", 32'(mem_en), 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Presents one request and holds it until its grant appears
    task automatic issue(input logic g, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        logic seen;
        seen = 1'b0;
        if (g) begin
            game_we = we; game_addr = a; game_wdata = wd; game_req = 1'b1;
        end else begin
            disp_addr = a; disp_req = 1'b1;
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk_in);
            #1;
            if (g ? game_gnt : disp_gnt) seen = 1'b1;
        end
        game_req = 1'b0;
        disp_req = 1'b0;
        check("issue_gnt_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_any(output logic who);
        logic seen;
        seen = 1'b0;
        who  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk_in);
            #1;
            if (disp_gnt || game_gnt) begin
                seen = 1'b1;
                who  = game_gnt;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_gnt_timeout: got no grant, expected one within 20 cycles");
        end
    endtask

    logic [9:0] pat;
    logic       who;

    initial begin
        rst = 1'b1; disp_req = 1'b1; game_req = 1'b1;
        disp_addr = 5'd0; game_addr = 5'd0; game_we = 1'b0; game_wdata = 10'd0;

        // 1: reset with both requests high
        repeat (3) begin
            @(negedge clk_in);
            check("rst_ctrl", {26'd0, disp_gnt, disp_rvalid, game_gnt, game_rvalid, mem_en, mem_we}, 32'd0);
            check("rst_mem_addr_wdata", {17'd0, mem_addr, mem_wdata}, 32'd0);
            check("rst_rdata", {12'd0, disp_rdata, game_rdata}, 32'd0);
        end
        @(posedge clk_in);
        #1;
        rst = 1'b0; disp_req = 1'b0; game_req = 1'b0;
        repeat (2) begin
            @(negedge clk_in);
            check("post_rst_mem_en", 32'(mem_en), 32'd0);
        end
        idle(1);

        // 2: display read of row 5
        exp_gnt(1'b0, 1'b0, 5'd5, 10'd0, 0);
        exp_rv(1'b0, 10'h3FF);
        issue(1'b0, 1'b0, 5'd5, 10'd0);
        idle(3);

        // 3: game write row 19 then read it back
        exp_gnt(1'b1, 1'b1, 5'd19, 10'h155, 0);
        issue(1'b1, 1'b1, 5'd19, 10'h155);
        idle(3);
        exp_gnt(1'b1, 1'b0, 5'd19, 10'd0, 0);
        exp_rv(1'b1, 10'h155);
        issue(1'b1, 1'b0, 5'd19, 10'd0);
        idle(3);

        // 4: both requests held; bit i = 1 means grant i goes to the game
`ifdef BOARD_ARB_RR_EN
        pat = 10'b1010101010;
`else
        pat = 10'b1000010000;
`endif
        for (int i = 0; i < 10; i++) begin
            exp_gnt(pat[i], 1'b0, pat[i] ? 5'd7 : 5'd3, 10'd0, (i == 0) ? 0 : 2);
            exp_rv(pat[i], pat[i] ? 10'h12C : 10'h0A5);
        end
        disp_addr = 5'd3; game_addr = 5'd7; game_we = 1'b0;
        disp_req = 1'b1; game_req = 1'b1;
        for (int i = 0; i < 10; i++) wait_any(who);
        disp_req = 1'b0; game_req = 1'b0;
        idle(3);

`ifndef BOARD_ARB_RR_EN
        // 5: game drops after two display wins; starvation count restarts
        for (int i = 0; i < 8; i++) begin
            exp_gnt(i == 7, 1'b0, (i == 7) ? 5'd7 : 5'd3, 10'd0, (i == 0) ? 0 : 2);
            exp_rv(i == 7, (i == 7) ? 10'h12C : 10'h0A5);
        end
        disp_req = 1'b1; game_req = 1'b1;
        wait_any(who);
        wait_any(who);
        game_req = 1'b0;
        wait_any(who);
        game_req = 1'b1;
        for (int i = 0; i < 5; i++) wait_any(who);
        disp_req = 1'b0; game_req = 1'b0;
        idle(3);
`endif

        // 6: reset during the access cycle of a game read
        exp_gnt(1'b1, 1'b0, 5'd19, 10'd0, 0);
        issue(1'b1, 1'b0, 5'd19, 10'd0);
        rst = 1'b1;
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        @(negedge clk_in);
        check("rst_mid_acc_game_rvalid", 32'(game_rvalid), 32'd0);
        check("rst_mid_acc_game_rdata", 32'(game_rdata), 32'd0);
        idle(1);
        exp_gnt(1'b0, 1'b0, 5'd5, 10'd0, 0);
        exp_rv(1'b0, 10'h3FF);
        issue(1'b0, 1'b0, 5'd5, 10'd0);
        idle(3);

        // Display rdata must hold while the game owns the response
        exp_gnt(1'b1, 1'b0, 5'd7, 10'd0, 0);
        exp_rv(1'b1, 10'h12C);
        issue(1'b1, 1'b0, 5'd7, 10'd0);
        @(negedge clk_in);
        @(negedge clk_in);
        check("disp_rdata_hold", 32'(disp_rdata), 32'h3FF);
        idle(3);

        check("gnt_queue_drained", 32'(gnt_q.size()), 32'd0);
        check("rv_queue_drained", 32'(rv_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
